// File: rtl/render_window_reader_if.sv
// render_window_reader_if: scan, BRAM port-B and VGA output bundle for the
// render-window read port. The master side drives the scan and the RAM data
// (signal generator plus BRAM). The slave side is the reader itself.
interface render_window_reader_if #(
    parameter int ADDR_WIDTH = 14
);
    logic [10:0]           hcount_in;
    logic [9:0]            vcount_in;
    logic                  hs_in;
    logic                  vs_in;
    logic                  ad_in;
    logic                  nf_in;
    logic [ADDR_WIDTH-1:0] addr_out;
    logic [23:0]           ram_data_in;
    logic [3:0]            vga_r_out;
    logic [3:0]            vga_g_out;
    logic [3:0]            vga_b_out;
    logic                  vga_hs_out;
    logic                  vga_vs_out;
    logic                  frame_err_out;

    modport master (
        output hcount_in, vcount_in, hs_in, vs_in, ad_in, nf_in, ram_data_in,
        input  addr_out, vga_r_out, vga_g_out, vga_b_out,
        input  vga_hs_out, vga_vs_out, frame_err_out
    );

    modport slave (
        input  hcount_in, vcount_in, hs_in, vs_in, ad_in, nf_in, ram_data_in,
        output addr_out, vga_r_out, vga_g_out, vga_b_out,
        output vga_hs_out, vga_vs_out, frame_err_out
    );
endinterface

// File: rtl/render_window_reader.sv
// render_window_reader: VGA-side read port of the render-window frame buffer.
// The BRAM address comes from an incremental counter rather than a per-pixel
// multiply. Sync and colour are realigned to the RAM read latency. A sticky
// flag reports any frame that did not read exactly AREA window pixels.
// Optional feature macro FB_BORDER_EN: paints the 1-px ring just outside the
// window white (12'hFFF). When it is undefined, ring pixels show BG_COLOR.
module render_window_reader #(
    parameter int          START_X     = 260,
    parameter int          START_Y     = 195,
    parameter int          END_X       = 390,
    parameter int          END_Y       = 295,
    parameter int          ADDR_WIDTH  = 14,
    parameter int          RAM_LATENCY = 2,
    parameter logic [11:0] BG_COLOR    = 12'h000
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    render_window_reader_if.slave bus
);
    // One cycle for the registered address, then the BRAM read latency.
    localparam int LAT  = 1 + RAM_LATENCY;
    localparam int AREA = (END_X - START_X) * (END_Y - START_Y);

    localparam logic [10:0]           X_LO      = 11'(START_X);
    localparam logic [10:0]           X_HI      = 11'(END_X);
    localparam logic [9:0]            Y_LO      = 10'(START_Y);
    localparam logic [9:0]            Y_HI      = 10'(END_Y);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(AREA - 1);

    logic                  in_win;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic                  wrapped;
    logic                  synced;
    logic                  frame_err;
    logic [LAT-1:0]        hs_d;
    logic [LAT-1:0]        vs_d;
    logic [LAT-1:0]        ad_d;
    logic [LAT-1:0]        win_d;
    logic [11:0]           rgb;
    logic                  unused_ram_bits;

    assign in_win = (bus.hcount_in >= X_LO) && (bus.hcount_in < X_HI) &&
                    (bus.vcount_in >= Y_LO) && (bus.vcount_in < Y_HI);

`ifdef FB_BORDER_EN
    localparam logic [10:0] RX_LO = 11'(START_X - 1);
    localparam logic [10:0] RX_HI = 11'(END_X);
    localparam logic [9:0]  RY_LO = 10'(START_Y - 1);
    localparam logic [9:0]  RY_HI = 10'(END_Y);

    logic           in_ring;
    logic [LAT-1:0] ring_d;

    assign in_ring = (bus.hcount_in >= RX_LO) && (bus.hcount_in <= RX_HI) &&
                     (bus.vcount_in >= RY_LO) && (bus.vcount_in <= RY_HI) &&
                     !in_win;

    // Delay the ring flag so that it lines up with the returning RAM data.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            ring_d <= '0;
        end else begin
            ring_d <= {ring_d[LAT-2:0], in_ring};
        end
    end
`endif

    // Address counter and frame-integrity check. nf_in restarts the count,
    // and a pixel arriving in the same cycle as nf_in consumes address 0.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            addr_q    <= '0;
            addr_r    <= '0;
            wrapped   <= 1'b0;
            synced    <= 1'b0;
            frame_err <= 1'b0;
        end else if (bus.nf_in) begin
            if (synced && (!wrapped || addr_q != '0)) begin
                frame_err <= 1'b1;
            end
            synced  <= 1'b1;
            wrapped <= 1'b0;
            addr_r  <= '0;
            addr_q  <= in_win ? ADDR_WIDTH'(1) : '0;
        end else if (in_win) begin
            addr_r <= addr_q;
            if (addr_q == LAST_ADDR) begin
                addr_q  <= '0;
                wrapped <= 1'b1;
            end else begin
                addr_q <= addr_q + ADDR_WIDTH'(1);
            end
        end else begin
            addr_r <= '0;
        end
    end

    // Scan-side delay lines that realign sync, active and window with RAM data.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            hs_d  <= '0;
            vs_d  <= '0;
            ad_d  <= '0;
            win_d <= '0;
        end else begin
            hs_d  <= {hs_d[LAT-2:0],  bus.hs_in};
            vs_d  <= {vs_d[LAT-2:0],  bus.vs_in};
            ad_d  <= {ad_d[LAT-2:0],  bus.ad_in};
            win_d <= {win_d[LAT-2:0], in_win};
        end
    end

    // Colour select: blank outside the active area, RAM inside the window,
    // optional white ring, background elsewhere.
    always_comb begin
        rgb = 12'h000;
        if (ad_d[LAT-1]) begin
            if (win_d[LAT-1]) begin
                rgb = {bus.ram_data_in[23:20], bus.ram_data_in[15:12], bus.ram_data_in[7:4]};
`ifdef FB_BORDER_EN
            end else if (ring_d[LAT-1]) begin
                rgb = 12'hFFF;
`endif
            end else begin
                rgb = BG_COLOR;
            end
        end
    end

    // Only the top nibble of each 8-bit channel is displayed.
    assign unused_ram_bits = ^{bus.ram_data_in[19:16], bus.ram_data_in[11:8],
                               bus.ram_data_in[3:0]};

    assign bus.addr_out      = addr_r;
    assign bus.vga_r_out     = rgb[11:8];
    assign bus.vga_g_out     = rgb[7:4];
    assign bus.vga_b_out     = rgb[3:0];
    assign bus.vga_hs_out    = hs_d[LAT-1];
    assign bus.vga_vs_out    = vs_d[LAT-1];
    assign bus.frame_err_out = frame_err;
endmodule

// File: tb/tb_render_window_reader.sv
// tb_render_window_reader: self-checking bench for render_window_reader.
// A per-period reference model derives the expected address from the count of
// window pixels since the last new-frame pulse. It derives the expected
// colour/sync from the scan sample taken three periods earlier.
module tb_render_window_reader;
    localparam int AREA = 13000;
    localparam int SX   = 260;
    localparam int SY   = 195;
    localparam int EX   = 390;
    localparam int EY   = 295;
    localparam int W    = EX - SX;
`ifdef FB_BORDER_EN
    localparam logic [11:0] RING_C = 12'hFFF;
`else
    localparam logic [11:0] RING_C = 12'h000;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    render_window_reader_if bus ();

    render_window_reader dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic hs;
        logic vs;
        logic ad;
        logic win;
        logic ring;
    } scan_t;

    typedef struct {
        int          h;
        int          v;
        bit          ad;
        logic [23:0] ram;
        logic [11:0] rgb;
    } vec_t;

    scan_t       hist [0:7];
    int          pn = 8;
    int          vec_cnt = 0;
    int          err_cnt = 0;
    bit          chk_on = 0;
    int unsigned m_cnt = 0;
    bit          m_synced = 0;
    bit          m_err = 0;
    int          m_addr = 0;

    int          cur_h, cur_v;
    bit          cur_hs, cur_vs, cur_ad, cur_nf, cur_rst;

    function automatic bit f_win(int h, int v);
        return (h >= SX) && (h < EX) && (v >= SY) && (v < EY);
    endfunction

    function automatic bit f_ring(int h, int v);
        return (h >= SX - 1) && (h <= EX) && (v >= SY - 1) && (v <= EY) && !f_win(h, v);
    endfunction

    function automatic logic [11:0] dut_rgb();
        return {bus.vga_r_out, bus.vga_g_out, bus.vga_b_out};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h (period %0d)", name, act, exp, pn);
        end
    endtask

    task automatic model_check();
        scan_t       e;
        logic [11:0] exp_rgb;
        e = hist[(pn - 3) % 8];
        if (!e.ad)          exp_rgb = 12'h000;
        else if (e.win)     exp_rgb = {bus.ram_data_in[23:20], bus.ram_data_in[15:12], bus.ram_data_in[7:4]};
        else if (e.ring)    exp_rgb = RING_C;
        else                exp_rgb = 12'h000;
        check("addr",  32'(bus.addr_out), 32'(m_addr));
        check("hs",    32'(bus.vga_hs_out), 32'(e.hs));
        check("vs",    32'(bus.vga_vs_out), 32'(e.vs));
        check("rgb",   32'(dut_rgb()), 32'(exp_rgb));
        check("err",   32'(bus.frame_err_out), 32'(m_err));
    endtask

    task automatic apply(input int h, input int v, input bit hs, input bit vs, input bit ad,
                         input bit nf, input logic [23:0] ram, input bit r);
        cur_h = h; cur_v = v; cur_hs = hs; cur_vs = vs; cur_ad = ad; cur_nf = nf; cur_rst = r;
        bus.hcount_in   = 11'(h);
        bus.vcount_in   = 10'(v);
        bus.hs_in       = hs;
        bus.vs_in       = vs;
        bus.ad_in       = ad;
        bus.nf_in       = nf;
        bus.ram_data_in = ram;
        rst             = r;
        #1;
        if (chk_on) model_check();
    endtask

    task automatic clock();
        bit w;
        @(posedge clk);
        #1;
        if (cur_rst) begin
            m_addr = 0; m_err = 0; m_synced = 0; m_cnt = 0;
            hist[pn % 8]       = '0;
            hist[(pn - 1) % 8] = '0;
            hist[(pn - 2) % 8] = '0;
        end else begin
            w = f_win(cur_h, cur_v);
            hist[pn % 8] = '{hs: cur_hs, vs: cur_vs, ad: cur_ad, win: w, ring: f_ring(cur_h, cur_v)};
            if (cur_nf) begin
                if (m_synced && (m_cnt < AREA || (m_cnt % AREA) != 0)) m_err = 1;
                m_synced = 1;
                m_cnt    = w ? 1 : 0;
                m_addr   = 0;
            end else if (w) begin
                m_addr = int'(m_cnt % AREA);
                m_cnt++;
            end else begin
                m_addr = 0;
            end
        end
        pn++;
    endtask

    task automatic idle(input logic [23:0] ram);
        apply(0, 0, 0, 0, 0, 0, ram, 0);
        clock();
    endtask

    task automatic nf_pulse();
        apply(0, 0, 0, 0, 0, 1, 24'h0, 0);
        clock();
    endtask

    task automatic do_reset();
        apply(0, 0, 0, 0, 0, 0, 24'h0, 1);
        clock();
        apply(0, 0, 0, 0, 0, 0, 24'h0, 1);
        clock();
    endtask

    task automatic frame_pix(input int n, input bit spot);
        for (int i = 0; i < n; i++) begin
            apply(SX + i % W, SY + i / W, 0, 0, 1, 0, 24'($urandom), 0);
            clock();
            if (spot && (i == 0 || i == 1 || i == 130 || i == 12999))
                check("addr_spot", 32'(bus.addr_out), 32'(i));
        end
    endtask

    vec_t vecs [12];

    initial begin
        for (int i = 0; i < 8; i++) hist[i] = '0;
        vecs[0]  = '{260, 195, 1'b1, 24'hF0A05F, 12'hFA5};
        vecs[1]  = '{389, 294, 1'b1, 24'h123456, 12'h135};
        vecs[2]  = '{100, 100, 1'b1, 24'hFFFFFF, 12'h000};
        vecs[3]  = '{260, 195, 1'b0, 24'hFFFFFF, 12'h000};
        vecs[4]  = '{390, 195, 1'b1, 24'hABCDEF, RING_C};
        vecs[5]  = '{259, 195, 1'b1, 24'hABCDEF, RING_C};
        vecs[6]  = '{258, 195, 1'b1, 24'hABCDEF, 12'h000};
        vecs[7]  = '{260, 295, 1'b1, 24'h777777, RING_C};
        vecs[8]  = '{260, 296, 1'b1, 24'h777777, 12'h000};
        vecs[9]  = '{259, 194, 1'b1, 24'h555555, RING_C};
        vecs[10] = '{325, 245, 1'b1, 24'h89ABCD, 12'h8AC};
        vecs[11] = '{389, 195, 1'b1, 24'hE1D2C3, 12'hEDC};

        // Reset held with the scan inside the window and RAM data all ones.
        for (int i = 0; i < 5; i++) begin
            apply(SX, SY, 1, 1, 1, 0, 24'hFFFFFF, 1);
            clock();
            chk_on = 1;
            check("rst_addr", 32'(bus.addr_out), 32'h0);
            check("rst_rgb",  32'(dut_rgb()), 32'h0);
            check("rst_hs",   32'(bus.vga_hs_out), 32'h0);
            check("rst_vs",   32'(bus.vga_vs_out), 32'h0);
            check("rst_err",  32'(bus.frame_err_out), 32'h0);
        end
        for (int i = 0; i < 3; i++) begin
            apply(SX + i, SY, 1, 1, 1, 0, 24'hFFFFFF, 0);
            check("post_rst_rgb", 32'(dut_rgb()), 32'h0);
            check("post_rst_hs",  32'(bus.vga_hs_out), 32'h0);
            check("post_rst_vs",  32'(bus.vga_vs_out), 32'h0);
            clock();
        end
        for (int i = 0; i < 3; i++) idle(24'h0);

        // Colour / window / ring table, each sample checked three periods later.
        foreach (vecs[k]) begin
            apply(vecs[k].h, vecs[k].v, 0, 0, vecs[k].ad, 0, 24'h0, 0);
            clock();
            idle(24'h0);
            idle(24'h0);
            apply(0, 0, 0, 0, 0, 0, vecs[k].ram, 0);
            check("tbl_rgb", 32'(dut_rgb()), 32'(vecs[k].rgb));
            clock();
        end

        // Sync alignment: 96-wide hs and vs pulses reappear three periods late.
        for (int i = 0; i < 120; i++) begin
            apply(0, 0, (i >= 5 && i < 101), (i >= 10 && i < 106), 0, 0, 24'h0, 0);
            check("hs_align", 32'(bus.vga_hs_out), 32'((i - 3 >= 5) && (i - 3 < 101)));
            check("vs_align", 32'(bus.vga_vs_out), 32'((i - 3 >= 10) && (i - 3 < 106)));
            clock();
        end

        // Addressing over a full frame, then wrap to 0 on the next window pixel.
        chk_on = 0;
        do_reset();
        nf_pulse();
        frame_pix(AREA, 1);
        apply(SX, SY, 0, 0, 1, 0, 24'h0, 0);
        clock();
        check("addr_wrap", 32'(bus.addr_out), 32'h0);
        nf_pulse();
        check("err_overrun", 32'(bus.frame_err_out), 32'h1);
        do_reset();
        check("err_rst_clear", 32'(bus.frame_err_out), 32'h0);

        // Integrity: sync, two good frames, a short frame, then a good frame.
        nf_pulse();
        check("err_first_nf", 32'(bus.frame_err_out), 32'h0);
        frame_pix(AREA, 0);
        nf_pulse();
        check("err_good1", 32'(bus.frame_err_out), 32'h0);
        frame_pix(AREA, 0);
        nf_pulse();
        check("err_good2", 32'(bus.frame_err_out), 32'h0);
        frame_pix(12000, 0);
        nf_pulse();
        check("err_short", 32'(bus.frame_err_out), 32'h1);
        frame_pix(AREA, 0);
        nf_pulse();
        check("err_sticky", 32'(bus.frame_err_out), 32'h1);
        do_reset();
        check("err_cleared", 32'(bus.frame_err_out), 32'h0);

        // Randomised scan around the window against the reference model.
        chk_on = 1;
        for (int i = 0; i < 3000; i++) begin
            apply(int'($urandom_range(395, 254)), int'($urandom_range(300, 189)),
                  bit'($urandom_range(1, 0)), bit'($urandom_range(1, 0)),
                  bit'($urandom_range(3, 0) != 0), ($urandom_range(63, 0) == 0),
                  24'($urandom), ($urandom_range(499, 0) == 0));
            clock();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
